// File: rtl/hpdcache_wbuf_flush_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_wbuf_flush_sched_if
// Purpose  : Bundles the control, send-channel and status signals of the
//            write-buffer flush scheduler.
//            master : directory / NoC side (drives alloc, write, flush,
//                     ready and ack; observes send and status).
//            slave  : the scheduler itself.
// Ports    : cfg_threshold_i, cfg_reset_timecnt_on_write_i,
//            alloc_i/alloc_idx_i, write_i/write_idx_i, flush_all_i,
//            send_valid_o/send_idx_o/send_ready_i, ack_i/ack_idx_i,
//            free_o, empty_o, full_o
// Revision : 1.0 - initial release
// ============================================================================
interface hpdcache_wbuf_flush_sched_if #(
  parameter int unsigned DIR_ENTRIES   = 4,
  parameter int unsigned TIMECNT_WIDTH = 4
);
  localparam int unsigned IDX_W = $clog2(DIR_ENTRIES);

  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i;
  logic                     cfg_reset_timecnt_on_write_i;
  logic                     alloc_i;
  logic [IDX_W-1:0]         alloc_idx_i;
  logic                     write_i;
  logic [IDX_W-1:0]         write_idx_i;
  logic                     flush_all_i;
  logic                     send_valid_o;
  logic [IDX_W-1:0]         send_idx_o;
  logic                     send_ready_i;
  logic                     ack_i;
  logic [IDX_W-1:0]         ack_idx_i;
  logic [DIR_ENTRIES-1:0]   free_o;
  logic                     empty_o;
  logic                     full_o;

  modport master (
    output cfg_threshold_i, cfg_reset_timecnt_on_write_i,
    output alloc_i, alloc_idx_i, write_i, write_idx_i, flush_all_i,
    output send_ready_i, ack_i, ack_idx_i,
    input  send_valid_o, send_idx_o, free_o, empty_o, full_o
  );

  modport slave (
    input  cfg_threshold_i, cfg_reset_timecnt_on_write_i,
    input  alloc_i, alloc_idx_i, write_i, write_idx_i, flush_all_i,
    input  send_ready_i, ack_i, ack_idx_i,
    output send_valid_o, send_idx_o, free_o, empty_o, full_o
  );
endinterface
`default_nettype wire

// File: rtl/hpdcache_wbuf_flush_sched.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_wbuf_flush_sched
// Purpose  : Per-entry FREE/OPEN/PEND/SENT lifecycle controller and send
//            scheduler for the HPDcache write-buffer directory. Open entries
//            close on timer threshold or flush; closed entries are arbitrated
//            onto the single send channel; acks free sent entries.
// Ports    : clk_i, rst_i (async, active-high), bus (slave modport of
//            hpdcache_wbuf_flush_sched_if).
// Options  : HPDCACHE_WBUF_SCHED_RR_EN      - round-robin arbitration
//                                             (default: lowest index wins)
//            HPDCACHE_WBUF_SCHED_ILLEGAL_CHK - run-time checks on alloc/write/
//                                             ack to entries in a wrong state
// Revision : 1.0 - initial release
// ============================================================================
module hpdcache_wbuf_flush_sched #(
  parameter int unsigned DIR_ENTRIES   = 4,
  parameter int unsigned TIMECNT_WIDTH = 4
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  hpdcache_wbuf_flush_sched_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DIR_ENTRIES);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_OPEN = 2'd1,
    ST_PEND = 2'd2,
    ST_SENT = 2'd3
  } entry_state_e;

  entry_state_e             r_state       [DIR_ENTRIES];
  entry_state_e             w_state_nxt   [DIR_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] r_timecnt     [DIR_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] w_timecnt_nxt [DIR_ENTRIES];

  logic                   r_lock;
  logic [IDX_W-1:0]       r_lock_idx;
  logic [DIR_ENTRIES-1:0] w_pend;
  logic [DIR_ENTRIES-1:0] w_free;
  logic                   w_any_pend;
  logic                   w_arb_found;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_send_valid;
  logic [IDX_W-1:0]       w_send_idx;
  logic                   w_hs;

  // --------------------------------------------------------------------------
  // State decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_pend = '0;
    w_free = '0;
    for (int i = 0; i < DIR_ENTRIES; i++) begin
      w_pend[i] = (r_state[i] == ST_PEND);
      w_free[i] = (r_state[i] == ST_FREE);
    end
  end

  assign w_any_pend = |w_pend;

  // --------------------------------------------------------------------------
  // Arbiter among PEND entries
  // --------------------------------------------------------------------------
`ifdef HPDCACHE_WBUF_SCHED_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_arb_cand;

  // Search starts at the pointer; the index arithmetic wraps naturally
  // because DIR_ENTRIES is a power of two.
  always_comb begin
    w_arb_idx   = '0;
    w_arb_found = 1'b0;
    w_arb_cand  = '0;
    for (int k = 0; k < DIR_ENTRIES; k++) begin
      w_arb_cand = r_rr_ptr + IDX_W'(k);
      if (!w_arb_found && w_pend[w_arb_cand]) begin
        w_arb_idx   = w_arb_cand;
        w_arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= w_send_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    w_arb_idx   = '0;
    w_arb_found = 1'b0;
    for (int k = 0; k < DIR_ENTRIES; k++) begin
      if (!w_arb_found && w_pend[k]) begin
        w_arb_idx   = IDX_W'(k);
        w_arb_found = 1'b1;
      end
    end
  end
`endif

  // A stalled offer stays locked on its entry so the index cannot change
  // under a valid that has not been accepted yet.
  assign w_send_valid = r_lock | w_any_pend;
  assign w_send_idx   = r_lock ? r_lock_idx : w_arb_idx;
  assign w_hs         = w_send_valid & bus.send_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_hs) begin
      r_lock     <= 1'b0;
    end else if (w_send_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_send_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Per-entry lifecycle: next state
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DIR_ENTRIES; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_timecnt_nxt[i] = r_timecnt[i];
      case (r_state[i])
        ST_FREE: begin
          if (bus.alloc_i && (bus.alloc_idx_i == IDX_W'(i))) begin
            w_state_nxt[i]   = ST_OPEN;
            w_timecnt_nxt[i] = '0;
          end
        end
        ST_OPEN: begin
          if (bus.flush_all_i) begin
            w_state_nxt[i] = ST_PEND;
          end else if (bus.write_i && (bus.write_idx_i == IDX_W'(i))) begin
            // A coalescing write holds the timer (or restarts it).
            if (bus.cfg_reset_timecnt_on_write_i) begin
              w_timecnt_nxt[i] = '0;
            end
          end else if (r_timecnt[i] >= bus.cfg_threshold_i) begin
            w_state_nxt[i] = ST_PEND;
          end else if (!(&r_timecnt[i])) begin
            w_timecnt_nxt[i] = r_timecnt[i] + TIMECNT_WIDTH'(1);
          end
        end
        ST_PEND: begin
          if (w_hs && (w_send_idx == IDX_W'(i))) begin
            w_state_nxt[i] = ST_SENT;
          end
        end
        ST_SENT: begin
          if (bus.ack_i && (bus.ack_idx_i == IDX_W'(i))) begin
            w_state_nxt[i] = ST_FREE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DIR_ENTRIES; i++) begin
        r_state[i]   <= ST_FREE;
        r_timecnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DIR_ENTRIES; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_timecnt[i] <= w_timecnt_nxt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.send_valid_o = w_send_valid;
  assign bus.send_idx_o   = w_send_idx;
  assign bus.free_o       = w_free;
  assign bus.empty_o      = &w_free;
  assign bus.full_o       = ~|w_free;

`ifdef HPDCACHE_WBUF_SCHED_ILLEGAL_CHK
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (bus.alloc_i) begin
        assert (r_state[bus.alloc_idx_i] == ST_FREE)
          else $error("alloc to a non-FREE entry");
      end
      if (bus.write_i) begin
        assert (r_state[bus.write_idx_i] == ST_OPEN)
          else $error("write to a non-OPEN entry");
      end
      if (bus.ack_i) begin
        assert (r_state[bus.ack_idx_i] == ST_SENT)
          else $error("ack to a non-SENT entry");
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/hpdcache_wbuf_flush_sched.md
# hpdcache_wbuf_flush_sched

Per-entry lifecycle controller and send scheduler for the HPDcache write-buffer directory. It tracks each directory entry through FREE/OPEN/PEND/SENT, closes open entries when their time counter reaches the programmed threshold or on a flush, and arbitrates closed entries onto the single write-buffer-to-NoC send channel. It sits between the write-buffer directory/data arrays and the memory write request interface, and frees entries on memory acknowledgement.

## Interface
- DIR_ENTRIES, default 4: number of write-buffer directory entries (power of two, ≥2).
- TIMECNT_WIDTH, default 4: width of each entry's time counter and of the threshold.
- IDX_W, derived $clog2(DIR_ENTRIES): entry index width.

- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- cfg_threshold_i  in  TIMECNT_WIDTH  close threshold, sampled every cycle.
- cfg_reset_timecnt_on_write_i  in  1  restart an entry's timer on a coalescing write.
- alloc_i  in  1  open a FREE entry.
- alloc_idx_i  in  IDX_W  entry to open.
- write_i  in  1  coalescing write into an OPEN entry.
- write_idx_i  in  IDX_W  entry written.
- flush_all_i  in  1  close every OPEN entry (fence/flush).
- send_valid_o  out  1  an entry is offered to the NoC.
- send_idx_o  out  IDX_W  entry offered.
- send_ready_i  in  1  NoC accepts the offered entry.
- ack_i  in  1  memory acknowledged a sent entry.
- ack_idx_i  in  IDX_W  acknowledged entry.
- free_o  out  DIR_ENTRIES  bitmap of FREE entries.
- empty_o  out  1  all entries FREE.
- full_o  out  1  no entry FREE.

## Operation
- Per-entry state: FREE, OPEN, PEND, SENT; per-entry timer t (TIMECNT_WIDTH bits).
- FREE→OPEN: alloc_i with alloc_idx_i naming a FREE entry; t←0. alloc_i to a non-FREE entry is ignored (assertion fires).
- OPEN, evaluated at each edge, in priority order:
  - flush_all_i → PEND.
  - write_i to this entry → stays OPEN; t←0 if cfg_reset_timecnt_on_write_i, else t unchanged.
  - t ≥ cfg_threshold_i → PEND.
  - else t←t+1 (saturating at all-ones).
- PEND→SENT: entry is send_idx_o while send_valid_o && send_ready_i.
- SENT→FREE: ack_i with ack_idx_i naming this entry. ack_i to a non-SENT entry is ignored (assertion fires).
- write_i to a non-OPEN entry is ignored (assertion fires).
- Arbitration: send_valid_o = lock_q || (any PEND). send_idx_o = lock_q ? idx_q : arbiter choice among PEND entries.
- Lock: send_valid_o && !send_ready_i sets lock_q and captures idx_q; handshake clears lock_q. send_idx_o is stable while valid and not ready.
- free_o, empty_o and full_o are decoded from registered state.

## Timing
- Reset values: every entry FREE, all t=0, lock_q=0, idx_q=0, RR pointer=0. Outputs: send_valid_o=0, send_idx_o=0, free_o=all ones, empty_o=1, full_o=0.
- Reset asserted mid-operation drops all entries to FREE immediately, including PEND and SENT entries. Outstanding acks after reset are ignored.
- Timer close latency: with no writes, alloc at edge k gives PEND after edge k+threshold+1. Threshold 0 gives PEND after edge k+1.
- flush_all_i at edge k: all OPEN entries are PEND after edge k.
- PEND to send_valid_o latency is 0: an entry that becomes PEND at edge k is offered in cycle k if it wins arbitration.
- One handshake per cycle maximum. The accepted entry is SENT after the edge, so it is never offered twice.
- Simultaneous events:
  - alloc and ack on the same idx: the alloc is ignored, because the entry is not FREE at the edge.
  - Handshake and ack on different entries in the same cycle are both honoured.
  - flush_all_i has no effect on PEND or SENT entries.
  - Timer saturation never wraps.

## Configuration
- HPDCACHE_WBUF_SCHED_RR_EN defined: round-robin arbitration. The search starts at the RR pointer. After each handshake the pointer becomes (send_idx_o+1) mod DIR_ENTRIES.
- Not defined: fixed priority, lowest PEND index wins. No pointer register.
- Lock behaviour is identical in both modes.

## Test plan
- Timer close: threshold=3, alloc idx 2 at edge 0, no writes → entry 2 PEND after edge 4; send_valid_o=1 with send_idx_o=2 in cycle 4; ready → SENT; ack → free_o=4'b1111, empty_o=1.
- Write restart: threshold=2, cfg_reset=1, alloc idx 0, write idx 0 every cycle for 5 cycles → stays OPEN; PEND 3 edges after the last write. Repeat with cfg_reset=0 → write only delays closing by one cycle per write.
- Flush and full: alloc entries 0–3, full_o=1; flush_all_i → all PEND next cycle. With ready held high, sends occur in order 0,1,2,3 in both modes (pointer starts at 0).
- Stability and round-robin (RR_EN defined): entries 1 and 3 PEND, ready=0 for 3 cycles, then entry 0 becomes PEND → send_idx_o stays 1. After the handshake the order is 3 then 0. Without RR_EN, the order is 1, 0, 3.
- Illegal and simultaneous events: alloc to an OPEN entry, ack to an OPEN entry, and alloc+ack on the same SENT idx → states unchanged apart from the ack freeing the SENT entry; assertions fire.
- Reset mid-operation: 2 SENT, 1 PEND, lock_q set; assert rst_i → free_o=all ones, send_valid_o=0 immediately; a later ack is ignored.
